// File: rtl/conware_frame_sequencer.sv
// conware_frame_sequencer: per-frame generation request then row-by-row board readout to the serializer over valid/ready
module conware_frame_sequencer #(
  parameter int WIDTH  = 8,
  parameter int HEIGHT = 8,
  parameter int AW     = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             continuous,
  input  logic             stop,
  output logic             gen_req,
  input  logic             gen_done,
  output logic             mem_rd_en,
  output logic [AW-1:0]    mem_rd_addr,
  input  logic [WIDTH-1:0] mem_rd_data,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_sof,
  output logic             out_eof,
  output logic             busy,
  output logic             frame_done,
  output logic [31:0]      frame_count,
  output logic [AW-1:0]    row_count
);
  typedef enum logic [2:0] {IDLE, GEN, FETCH, LOAD, PRESENT, DONE} state_t;
  state_t state, state_nx;
  logic stop_pend;
  logic last;
  assign last = row_count == AW'(HEIGHT - 1);
  always_ff @(posedge clk)
    if (!rstn) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = start ? GEN : IDLE;
      GEN:     state_nx = gen_done ? FETCH : GEN;
      FETCH:   state_nx = LOAD;
      LOAD:    state_nx = PRESENT;
      PRESENT: state_nx = out_ready ? (last ? DONE : FETCH) : PRESENT;
      DONE:    state_nx = (continuous && !stop_pend && !stop) ? GEN : IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    gen_req     = state == GEN;
    mem_rd_en   = state == FETCH;
    mem_rd_addr = row_count;
    out_valid   = state == PRESENT;
    busy        = state != IDLE;
    frame_done  = state == DONE;
  end
  always_ff @(posedge clk)
    if (!rstn) begin
      out_data    <= '0;
      out_sof     <= 1'b0;
      out_eof     <= 1'b0;
      frame_count <= '0;
      row_count   <= '0;
      stop_pend   <= 1'b0;
    end else begin
      if (state == LOAD) begin
        out_data <= mem_rd_data;
        out_sof  <= row_count == '0;
        out_eof  <= last;
      end
      if ((state == IDLE && start) || state == DONE) row_count <= '0;
      else if (state == PRESENT && out_ready && !last) row_count <= row_count + 1'b1;
      if (state == DONE) frame_count <= frame_count + 32'd1;
      if (state == DONE) stop_pend <= 1'b0;
      else if (stop && (state != IDLE || start)) stop_pend <= 1'b1;
    end
endmodule

// File: tb/tb_conware_frame_sequencer.sv
// tb_conware_frame_sequencer: directed + randomized checks of the frame sequencer against a frame-level model
module tb_conware_frame_sequencer;
  localparam int W = 8, H = 8, AW = 8;
  logic clk = 1'b0, rstn = 1'b0, start = 1'b0, continuous = 1'b0, stop = 1'b0;
  logic gen_done = 1'b0, out_ready = 1'b0;
  logic gen_req, mem_rd_en, out_valid, out_sof, out_eof, busy, frame_done;
  logic [AW-1:0] mem_rd_addr, row_count;
  logic [W-1:0] mem_rd_data = '0, out_data;
  logic [31:0] frame_count;
  logic [W-1:0] ram [2**AW];
  logic [W+1:0] recv [$];
  logic [W+2:0] held;
  logic [31:0] exp_cnt = '0;
  int vecs = 0, errs = 0, done_cnt = 0, dsave = 0;
  always #5 clk = ~clk;
  conware_frame_sequencer #(.WIDTH(W), .HEIGHT(H), .AW(AW)) dut (
    .clk(clk), .rstn(rstn), .start(start), .continuous(continuous), .stop(stop),
    .gen_req(gen_req), .gen_done(gen_done), .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eof(out_eof), .busy(busy), .frame_done(frame_done),
    .frame_count(frame_count), .row_count(row_count)
  );
  always @(posedge clk) begin
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
    if (rstn && out_valid && out_ready) recv.push_back({out_sof, out_eof, out_data});
    if (rstn && frame_done) done_cnt++;
  end
  function automatic logic [63:0] outs();
    return 64'({gen_req, mem_rd_en, mem_rd_addr, out_data, out_valid, out_sof, out_eof,
                busy, frame_done, frame_count, row_count});
  endfunction
  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    vecs++;
    assert (o === e) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic pulse_start();
    start = 1'b1;
    step(1);
    start = 1'b0;
  endtask
  task automatic wait_gen();
    int n = 0;
    while (!gen_req && n < 50) begin step(1); n++; end
    chk("gen_req_wait", 64'(gen_req), 64'd1);
  endtask
  task automatic give_gen(input int d);
    step(d);
    gen_done = 1'b1;
    step(1);
    gen_done = 1'b0;
  endtask
  task automatic wait_done(input bit rnd);
    int n = 0;
    while (!frame_done && n < 400) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      step(1);
      n++;
    end
    out_ready = 1'b1;
    chk("frame_done_wait", 64'(frame_done), 64'd1);
    exp_cnt++;
  endtask
  task automatic wait_row(input int r);
    int n = 0;
    while (!(out_valid && row_count == AW'(r)) && n < 100) begin step(1); n++; end
    chk($sformatf("row%0d_reached", r), 64'({out_valid, row_count}), 64'({1'b1, AW'(r)}));
  endtask
  task automatic check_frame(input string tag);
    chk({tag, "_rows"}, 64'(recv.size()), 64'(H));
    for (int r = 0; r < H && r < recv.size(); r++)
      chk($sformatf("%s_row%0d", tag, r), 64'(recv[r]), 64'({r == 0, r == H - 1, ram[r]}));
    recv.delete();
    chk({tag, "_count"}, 64'(frame_count), 64'(exp_cnt));
  endtask
  task automatic rand_ram();
    for (int i = 0; i < H; i++) ram[i] = W'($urandom);
  endtask
  initial begin
    for (int i = 0; i < 2**AW; i++) ram[i] = W'(1 << i);
    step(3);
    chk("reset_outputs", outs(), 64'd0);
    rstn = 1'b1;
    step(1);
    out_ready = 1'b1;
    pulse_start();
    wait_gen();
    chk("busy_in_gen", 64'(busy), 64'd1);
    give_gen(3);
    chk("gen_req_drop_fetch", 64'({gen_req, mem_rd_en, mem_rd_addr}), 64'({1'b0, 1'b1, 8'h00}));
    step(1);
    chk("load_no_valid", 64'(out_valid), 64'd0);
    step(1);
    chk("first_present", 64'({out_valid, out_sof, out_eof, out_data}), 64'({3'b110, ram[0]}));
    wait_done(1'b0);
    step(1);
    check_frame("single");
    chk("single_idle", 64'({busy, gen_req}), 64'd0);
    step(2);
    chk("single_done_once", 64'(done_cnt), 64'd1);
    rand_ram();
    pulse_start();
    wait_gen();
    give_gen(int'($urandom_range(0, 4)));
    wait_row(3);
    out_ready = 1'b0;
    held = {out_valid, out_sof, out_eof, out_data};
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin start = 1'b1; gen_done = 1'b1; end
      step(1);
      start = 1'b0;
      gen_done = 1'b0;
      chk($sformatf("bp_hold%0d", i), 64'({out_valid, out_sof, out_eof, out_data, row_count}),
          64'({held, 8'd3}));
    end
    out_ready = 1'b1;
    wait_done(1'b0);
    step(1);
    check_frame("bp");
    chk("bp_done_cnt", 64'(done_cnt), 64'd2);
    rand_ram();
    continuous = 1'b1;
    pulse_start();
    for (int f = 0; f < 3; f++) begin
      wait_gen();
      if (f == 2) begin
        stop = 1'b1;
        step(1);
        stop = 1'b0;
        step(2);
        chk("stop_in_gen_holds", 64'({gen_req, busy}), 64'b11);
      end
      give_gen(int'($urandom_range(0, 3)));
      wait_done(f == 1);
      step(1);
      check_frame($sformatf("cont%0d", f));
      if (f < 2) chk($sformatf("cont%0d_regen", f), 64'(gen_req), 64'd1);
      else chk("cont_stop_idle", 64'({busy, gen_req}), 64'd0);
    end
    continuous = 1'b0;
    chk("cont_done_cnt", 64'(done_cnt), 64'd5);
    rand_ram();
    pulse_start();
    wait_gen();
    give_gen(1);
    wait_row(4);
    dsave = done_cnt;
    rstn = 1'b0;
    step(1);
    chk("midreset_outputs", outs(), 64'd0);
    rstn = 1'b1;
    exp_cnt = '0;
    recv.delete();
    step(1);
    chk("midreset_no_done", 64'(done_cnt), 64'(dsave));
    pulse_start();
    wait_gen();
    give_gen(2);
    chk("restart_row0", 64'({mem_rd_en, mem_rd_addr}), 64'({1'b1, 8'h00}));
    wait_done(1'b1);
    step(1);
    check_frame("restart");
    force dut.frame_count = 32'hFFFF_FFFF;
    step(1);
    release dut.frame_count;
    step(1);
    exp_cnt = 32'hFFFF_FFFF;
    chk("forced_max", 64'(frame_count), 64'(exp_cnt));
    rand_ram();
    pulse_start();
    wait_gen();
    give_gen(0);
    wait_done(1'b1);
    step(1);
    check_frame("wrap");
    chk("wrap_zero", 64'(frame_count), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule
